n101_ahb_mst_bpty: RTL and testbench
====================================

// Module: n101_ahb_mst_bpty
// PURPOSE
// - Master-side (core-side) AHB-Lite bus-parity block for ILM, DLM and MEM ports, one instance per port.
// - Generates command, address and write-data parity towards the subsystem.
// - Tracks the address/data pipeline and checks returned read-data and response parity.
// - Logs parity errors and raises a sticky phfatal toward the core error logic.
// PARAMETERS
// - ADDR_SIZE  32  haddr width, 1..32; bits above ADDR_SIZE are taken as 0 for parity
// - CNT_W      8   width of the saturating error counter
// PORTS
// - clk         in   1          core clock
// - rst         in   1          asynchronous reset, active-high
// - bptylvl     in   1          parity sense: 0 = even, 1 = odd
// - htrans      in   2          AHB command signals from the master, address phase
// - hwrite      in   1          AHB command signal, address phase
// - hsize       in   3          AHB command signal, address phase
// - hburst      in   3          AHB command signal, address phase
// - hprot       in   4          AHB command signal, address phase
// - hmastlock   in   1          AHB command signal, address phase
// - master      in   2          AHB command signal, address phase
// - haddr       in   ADDR_SIZE  address, address phase
// - hwdata      in   32         write data, data phase
// - hrdata      in   32         read data from the subsystem
// - hresp       in   2          response from the subsystem
// - hready      in   1          bus ready from the subsystem
// - hrdatabpty  in   4          read-data parity, one bit per byte
// - hrspbpty    in   1          response parity
// - hcmdbpty    out  2          command parity
// - haddrbpty   out  4          address parity, one bit per byte
// - hwdatabpty  out  4          write-data parity, one bit per byte
// - err_clr     in   1          clears err_sticky, err_type and err_cnt
// - err_pulse   out  1          one-cycle pulse per errored cycle
// - err_type    out  2          sticky OR of error kinds: [0] = rdata, [1] = resp
// - err_cnt     out  CNT_W      count of errored cycles, saturating
// - phfatal     out  1          sticky fatal parity error
// BEHAVIOUR
// - Parity function: P(x) = ^x ^ bptylvl.
// - Generated outputs are combinational, zero latency:
//   - hcmdbpty[0] = P({htrans,hwrite,hsize,hburst})
//   - hcmdbpty[1] = P({hprot,hmastlock,master})
//   - haddrbpty[i] = P(haddr32[8i+7:8i])
//   - hwdatabpty[i] = P(hwdata[8i+7:8i])
// - Data-phase tracker, states IDLE / DRD / DWR:
//   - The tracker updates only when hready=1.
//   - If htrans[1]=1 (NONSEQ/SEQ), the next state is DRD when hwrite=0 and DWR when hwrite=1.
//   - Otherwise the next state is IDLE.
//   - While hready=0 the state holds, covering wait states and the first cycle of a 2-cycle ERROR response.
// - Response check:
//   - Applies in every cycle where state != IDLE.
//   - The checked value is hrspbpty != P({hresp,hready}).
// - Read-data check:
//   - Applies only when state = DRD, hready=1 and hresp=OKAY.
//   - The checked value is hrdatabpty[i] != P(hrdata byte i), per byte.
//   - No rdata check on ERROR responses, on DWR, or in IDLE.
// - Error cycle: err_now = resp_err | rdata_err. Error outputs are registered, one cycle after the offending cycle:
//   - err_pulse <= err_now.
//   - err_type  <= err_type | {resp_err, rdata_err}.
//   - err_cnt   <= err_cnt + err_now, saturating at all-ones with no wrap.
//   - phfatal   <= phfatal | err_now.
// - err_clr, synchronous:
//   - Sets err_type, err_cnt and phfatal to 0 on the next edge.
//   - If err_now is also true in the same cycle, err_now wins: the new error is logged with err_cnt = 1.
//   - err_pulse is unaffected by err_clr.
// - Reset: state = IDLE; err_pulse, err_type, err_cnt and phfatal = 0.
//   - Reset asserted mid-transfer abandons the data phase, and no check is made in the reset cycles.
//   - The combinational parity outputs stay live during reset.
// - bptylvl is quasi-static. Changing it during a transfer is allowed; the checks use its current value.
// CONFIGURATION
// - Macro N101_BPTY_ERR_ADDR_CAPT_EN.
// - When defined:
//   - Adds output err_addr[ADDR_SIZE-1:0], reset 0.
//   - haddr is registered into a data-phase address on every accepted address phase.
//   - On the first err_now while phfatal=0, err_addr latches that data-phase address. Later errors do not overwrite it.
//   - err_clr re-arms the capture.
// - When undefined: no err_addr port, no address register; all other behaviour is identical.
// TESTING
// - bptylvl=0, haddr=32'h0000_0101, hwdata=32'hFF00_0001 -> haddrbpty=4'b0011, hwdatabpty=4'b0001. With bptylvl=1, both invert.
// - NONSEQ read, hready=1, hrdata=32'h0000_0003 with correct parity, then next read with hrdatabpty[2] flipped -> first: no error; second: err_pulse=1 one cycle after, err_type=2'b01, err_cnt=1, phfatal=1.
// - Write data phase with 3 wait states, hrspbpty wrong in wait cycle 2 -> exactly one err_pulse, err_type=2'b10; bad hrdatabpty ignored on the write.
// - Corrupt resp parity on 300 consecutive data-phase cycles, CNT_W=8 -> err_cnt stops at 255; err_clr asserted with no new error -> all error outputs 0 next cycle.
// - Corrupt rdata parity with err_clr high in the same cycle -> err_cnt=1 and phfatal=1 after the edge.
// - Capture macro on: errors at data-phase address 0x100 then 0x200 -> err_addr=0x100; err_clr, then error at 0x300 -> err_addr=0x300.
// - Reset asserted mid data phase with bad parity -> no error logged; state IDLE after release.

Source files
------------

// File: rtl/n101_ahb_mst_bpty.sv
// n101_ahb_mst_bpty - master-side AHB-Lite bus-parity block.
// Generates command, address and write-data parity towards the subsystem.
// Tracks the data phase and checks the returned read-data and response parity.
// Logs parity errors and raises a sticky phfatal.
// Optional feature macro: N101_BPTY_ERR_ADDR_CAPT_EN adds err_addr, the
// data-phase address of the first error since reset or the last err_clr.
module n101_ahb_mst_bpty #(
   parameter int ADDR_SIZE = 32,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bptylvl,
   input  logic [1:0]           htrans,
   input  logic                 hwrite,
   input  logic [2:0]           hsize,
   input  logic [2:0]           hburst,
   input  logic [3:0]           hprot,
   input  logic                 hmastlock,
   input  logic [1:0]           master,
   input  logic [ADDR_SIZE-1:0] haddr,
   input  logic [31:0]          hwdata,
   input  logic [31:0]          hrdata,
   input  logic [1:0]           hresp,
   input  logic                 hready,
   input  logic [3:0]           hrdatabpty,
   input  logic                 hrspbpty,
   output logic [1:0]           hcmdbpty,
   output logic [3:0]           haddrbpty,
   output logic [3:0]           hwdatabpty,
   input  logic                 err_clr,
   output logic                 err_pulse,
   output logic [1:0]           err_type,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 phfatal
`ifdef N101_BPTY_ERR_ADDR_CAPT_EN
   ,
   output logic [ADDR_SIZE-1:0] err_addr
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRD,
      ST_DWR
   } state_t;

   localparam logic [1:0]       RESP_OKAY = 2'b00;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] haddr32;
   logic [3:0]  rd_par;
   logic        rsp_par;
   logic        resp_err;
   logic        rdata_err;
   logic        err_now;

   // Address bits above ADDR_SIZE are treated as zero for parity
   assign haddr32 = 32'(haddr);

   // Outgoing parity and expected incoming parity, all purely combinational
   always_comb begin
      hcmdbpty   = '0;
      haddrbpty  = '0;
      hwdatabpty = '0;
      rd_par     = '0;
      hcmdbpty[0] = ^{htrans, hwrite, hsize, hburst} ^ bptylvl;
      hcmdbpty[1] = ^{hprot, hmastlock, master} ^ bptylvl;
      for (int i = 0; i < 4; i++) begin
         haddrbpty[i]  = ^haddr32[8*i +: 8] ^ bptylvl;
         hwdatabpty[i] = ^hwdata[8*i +: 8] ^ bptylvl;
         rd_par[i]     = ^hrdata[8*i +: 8] ^ bptylvl;
      end
      rsp_par = ^{hresp, hready} ^ bptylvl;
   end

   // Data-phase tracker register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next data phase follows the accepted address phase; hold during wait states
   always_comb begin
      state_nxt = state;
      if (hready) begin
         if (htrans[1]) begin
            state_nxt = hwrite ? ST_DWR : ST_DRD;
         end else begin
            state_nxt = ST_IDLE;
         end
      end
   end

   // Response parity is checked on every data-phase cycle, read data only on a completed OKAY read
   always_comb begin
      resp_err  = (state != ST_IDLE) && (hrspbpty != rsp_par);
      rdata_err = (state == ST_DRD) && hready && (hresp == RESP_OKAY) &&
                  (|(hrdatabpty ^ rd_par));
      err_now   = resp_err | rdata_err;
   end

   // Error logging; a fresh error in the clear cycle is logged as the first one after the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_pulse <= 1'b0;
         err_type  <= '0;
         err_cnt   <= '0;
         phfatal   <= 1'b0;
      end else begin
         err_pulse <= err_now;
         if (err_clr) begin
            err_type <= {resp_err, rdata_err};
            err_cnt  <= err_now ? CNT_ONE : '0;
            phfatal  <= err_now;
         end else begin
            err_type <= err_type | {resp_err, rdata_err};
            if (err_now && (err_cnt != '1)) begin
               err_cnt <= err_cnt + CNT_ONE;
            end
            phfatal <= phfatal | err_now;
         end
      end
   end

`ifdef N101_BPTY_ERR_ADDR_CAPT_EN
   logic [ADDR_SIZE-1:0] addr_dp;

   // Remember the address belonging to the upcoming data phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_dp <= '0;
      end else if (hready && htrans[1]) begin
         addr_dp <= haddr;
      end
   end

   // Capture only the first error; err_clr re-arms the capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_addr <= '0;
      end else if (err_now && (!phfatal || err_clr)) begin
         err_addr <= addr_dp;
      end
   end
`endif

endmodule

// File: tb/tb_n101_ahb_mst_bpty.sv
// tb_n101_ahb_mst_bpty - scoreboard bench for n101_ahb_mst_bpty.
// The driver pushes hand-computed expected error outputs for every cycle;
// a monitor pops and compares them one cycle later.
module tb_n101_ahb_mst_bpty;

   typedef struct {
      logic       pulse;
      logic [1:0] typ;
      logic [7:0] cnt;
      logic       fatal;
      string      tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        bptylvl;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic [1:0]  master;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic [1:0]  hresp;
   logic        hready;
   logic [3:0]  hrdatabpty;
   logic        hrspbpty;
   logic [1:0]  hcmdbpty;
   logic [3:0]  haddrbpty;
   logic [3:0]  hwdatabpty;
   logic        err_clr;
   logic        err_pulse;
   logic [1:0]  err_type;
   logic [7:0]  err_cnt;
   logic        phfatal;
`ifdef N101_BPTY_ERR_ADDR_CAPT_EN
   logic [31:0] err_addr;
`endif

   exp_t  sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   string cur_tag  = "reset";

   n101_ahb_mst_bpty #(.ADDR_SIZE(32), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bptylvl    (bptylvl),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .hsize      (hsize),
      .hburst     (hburst),
      .hprot      (hprot),
      .hmastlock  (hmastlock),
      .master     (master),
      .haddr      (haddr),
      .hwdata     (hwdata),
      .hrdata     (hrdata),
      .hresp      (hresp),
      .hready     (hready),
      .hrdatabpty (hrdatabpty),
      .hrspbpty   (hrspbpty),
      .hcmdbpty   (hcmdbpty),
      .haddrbpty  (haddrbpty),
      .hwdatabpty (hwdatabpty),
      .err_clr    (err_clr),
      .err_pulse  (err_pulse),
      .err_type   (err_type),
      .err_cnt    (err_cnt),
      .phfatal    (phfatal)
`ifdef N101_BPTY_ERR_ADDR_CAPT_EN
      ,
      .err_addr   (err_addr)
`endif
   );

   // Free-running clock, posedge at 5, 15, ...
   always #5 clk = ~clk;

   // Correct per-byte parity of a data word for the subsystem side to return
   function automatic logic [3:0] bytePar(input logic [31:0] d, input logic lvl);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8] ^ lvl;
      return p;
   endfunction

   // Direct comparison for combinational outputs and err_addr
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Drive one bus cycle and queue the error outputs expected after its edge
   task automatic applyStimulus(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                                input logic [31:0] rdata, input logic bad_rd, input logic bad_rsp,
                                input logic rdy, input logic [1:0] resp, input logic clr,
                                input logic e_pulse, input logic [1:0] e_type,
                                input logic [7:0] e_cnt, input logic e_fatal);
      exp_t e;
      htrans     = trans;
      hwrite     = write;
      haddr      = addr;
      hrdata     = rdata;
      hready     = rdy;
      hresp      = resp;
      err_clr    = clr;
      hrdatabpty = bytePar(rdata, bptylvl) ^ (bad_rd ? 4'b0100 : 4'b0000);
      hrspbpty   = (^{resp, rdy}) ^ bptylvl ^ bad_rsp;
      e.pulse = e_pulse;
      e.typ   = e_type;
      e.cnt   = e_cnt;
      e.fatal = e_fatal;
      e.tag   = cur_tag;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one expected entry per clock edge, compared just after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if ({err_pulse, err_type, err_cnt, phfatal} !== {e.pulse, e.typ, e.cnt, e.fatal}) begin
            n_fail++;
            $display("[TB] FAIL %s: got pulse=%0b type=%b cnt=%0d fatal=%0b, expected pulse=%0b type=%b cnt=%0d fatal=%0b",
                     e.tag, err_pulse, err_type, err_cnt, phfatal, e.pulse, e.typ, e.cnt, e.fatal);
         end
      end
   end

   initial begin
      rst = 1'b1; bptylvl = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
      hburst = 3'b000; hprot = 4'b0000; hmastlock = 1'b0; master = 2'b00;
      haddr = '0; hwdata = '0; hrdata = '0; hresp = 2'b00; hready = 1'b1;
      hrdatabpty = '0; hrspbpty = 1'b0; err_clr = 1'b0;
      @(negedge clk);

      // Generated parity is live while reset is held
      haddr = 32'h0000_0101; hwdata = 32'hFF00_0001; htrans = 2'b10; hwrite = 1'b0;
      hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0; master = 2'b01;
      #1;
      checkOutput("haddrbpty_even", 32'(haddrbpty), 32'h3);
      checkOutput("hwdatabpty_even", 32'(hwdatabpty), 32'h1);
      checkOutput("hcmdbpty_even", 32'(hcmdbpty), 32'h2);
      bptylvl = 1'b1;
      #1;
      checkOutput("haddrbpty_odd", 32'(haddrbpty), 32'hC);
      checkOutput("hwdatabpty_odd", 32'(hwdatabpty), 32'hE);
      checkOutput("hcmdbpty_odd", 32'(hcmdbpty), 32'h1);
      htrans = 2'b11; hwrite = 1'b1; hburst = 3'b001; hprot = 4'b0000; hmastlock = 1'b1;
      master = 2'b00; bptylvl = 1'b0;
      #1;
      checkOutput("hcmdbpty_burst", 32'(hcmdbpty), 32'h3);
      bptylvl = 1'b0;

      cur_tag = "reset";
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      rst = 1'b0;

      // Good read then read with flipped byte-2 parity
      cur_tag = "rdata";
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b10, 0, 32'h4, 32'h3, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h3, 1, 0, 1, 2'b00, 0, 1, 2'b01, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b01, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);

      // Write with 3 wait states, bad response parity in wait 2, bad rdata parity ignored
      cur_tag = "write_wait";
      applyStimulus(2'b10, 1, 32'h40, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h55, 1, 0, 0, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h55, 1, 1, 0, 2'b00, 0, 1, 2'b10, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h55, 1, 0, 0, 2'b00, 0, 0, 2'b10, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h55, 1, 0, 1, 2'b00, 0, 0, 2'b10, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);

      // 300 back-to-back bad response parities saturate the counter
      cur_tag = "saturate";
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      for (int i = 1; i <= 300; i++) begin
         applyStimulus((i < 300) ? 2'b10 : 2'b00, 0, 32'h0, 32'h0, 0, 1, 1, 2'b00, 0,
                       1, 2'b10, (i > 255) ? 8'd255 : 8'(i), 1);
      end
      cur_tag = "clear";
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);

      // Error in the same cycle as err_clr restarts the log at one
      cur_tag = "clr_vs_err";
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 1, 1, 2'b00, 0, 1, 2'b10, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h7, 1, 0, 1, 2'b00, 1, 1, 2'b01, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);

`ifdef N101_BPTY_ERR_ADDR_CAPT_EN
      // First error address is held until err_clr re-arms the capture
      cur_tag = "capture";
      applyStimulus(2'b10, 0, 32'h100, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b10, 0, 32'h200, 32'h9, 1, 0, 1, 2'b00, 0, 1, 2'b01, 8'd1, 1);
      applyStimulus(2'b00, 0, 32'h0, 32'h9, 1, 0, 1, 2'b00, 0, 1, 2'b01, 8'd2, 1);
      checkOutput("err_addr_first", err_addr, 32'h100);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b10, 0, 32'h300, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h9, 1, 0, 1, 2'b00, 0, 1, 2'b01, 8'd1, 1);
      checkOutput("err_addr_rearm", err_addr, 32'h300);
      applyStimulus(2'b00, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 1, 0, 2'b00, 8'd0, 0);
`endif

      // Odd sense read, then ERROR response with bad rdata parity is not an rdata error
      cur_tag = "odd_and_errresp";
      bptylvl = 1'b1;
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b10, 0, 32'h8, 32'hA5A5_0F01, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h1234, 1, 0, 0, 2'b01, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'h1234, 1, 0, 1, 2'b01, 0, 0, 2'b00, 8'd0, 0);
      bptylvl = 1'b0;

      // Reset mid data phase abandons it; bad parity afterwards in IDLE is ignored
      cur_tag = "reset_mid";
      applyStimulus(2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      rst = 1'b1;
      applyStimulus(2'b00, 0, 32'h0, 32'hF0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'hF0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      rst = 1'b0;
      applyStimulus(2'b00, 0, 32'h0, 32'hF0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(2'b00, 0, 32'h0, 32'hF0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 8'd0, 0);

      // Let the monitor drain the scoreboard, with a bounded wait
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
